// File: rtl/triplet_packer_pkg.sv
// Shared constants for the triplet packer and the downstream three-operand adder.
// Slot encoding names the next operand position to be filled.
package triplet_packer_pkg;

   localparam int DATA_W      = 32;
   localparam int TRIPLET_LEN = 3;

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2
   } slot_e;

endpackage

// File: rtl/triplet_packer.sv
// Packs a serial word stream into operand triplets (a, b, c) for a 3-input adder.
// Frames ending early are zero-padded; all state moves on the falling clock edge.
module triplet_packer #(
   parameter int DATA_W = triplet_packer_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_c,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
);

   import triplet_packer_pkg::*;

   slot_e             slot_q, slot_d;
   logic [DATA_W-1:0] hold0_q, hold0_d;
   logic [DATA_W-1:0] hold1_q, hold1_d;
   logic [DATA_W-1:0] out_a_q, out_a_d;
   logic [DATA_W-1:0] out_b_q, out_b_d;
   logic [DATA_W-1:0] out_c_q, out_c_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              accept;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_c     = out_c_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

   always_comb begin
      slot_d      = slot_q;
      hold0_d     = hold0_q;
      hold1_d     = hold1_q;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_c_d     = out_c_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      // A consumed triplet drops valid unless a new one lands below.
      if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      if (accept) begin
         unique case (slot_q)
            SLOT0: begin
               if (in_last) begin
                  out_a_d     = in_data;
                  out_b_d     = '0;
                  out_c_d     = '0;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b1;
                  slot_d      = SLOT0;
               end else begin
                  hold0_d = in_data;
                  slot_d  = SLOT1;
               end
            end
            SLOT1: begin
               if (in_last) begin
                  out_a_d     = hold0_q;
                  out_b_d     = in_data;
                  out_c_d     = '0;
                  out_valid_d = 1'b1;
                  out_last_d  = 1'b1;
                  slot_d      = SLOT0;
               end else begin
                  hold1_d = in_data;
                  slot_d  = SLOT2;
               end
            end
            SLOT2: begin
               out_a_d     = hold0_q;
               out_b_d     = hold1_q;
               out_c_d     = in_data;
               out_valid_d = 1'b1;
               out_last_d  = in_last;
               slot_d      = SLOT0;
            end
            default: slot_d = SLOT0;
         endcase
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         slot_q      <= SLOT0;
         hold0_q     <= '0;
         hold1_q     <= '0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_c_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         hold0_q     <= hold0_d;
         hold1_q     <= hold1_d;
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_c_q     <= out_c_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule

// File: tb/tb_triplet_packer.sv
// Directed bench for triplet_packer: expected triplets queued as words are driven,
// popped by a monitor whenever a triplet is handed to the consumer.
module tb_triplet_packer;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        last;
   } trip_t;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [31:0] out_c;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;

   int    nvec;
   int    nfail;
   int    cyc;
   trip_t expq[$];
   int    vcyc[$];

   triplet_packer #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs change on negedge; sample mid-high-phase, before the next capture.
   always @(posedge clk) begin
      #3;
      if (rst && out_valid) vcyc.push_back(cyc);
      if (rst && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            chk("sb_unexpected", out_a, 32'hDEAD_BEEF);
         end else begin
            trip_t e;
            e = expq.pop_front();
            chk("sb_a", out_a, e.a);
            chk("sb_b", out_b, e.b);
            chk("sb_c", out_c, e.c);
            chk("sb_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic l);
      @(posedge clk);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic l);
      trip_t t;
      t.a    = a;
      t.b    = b;
      t.c    = c;
      t.last = l;
      expq.push_back(t);
   endtask

   initial begin
      nvec      = 0;
      nfail     = 0;
      cyc       = 0;
      rst       = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #7;
      chk("rst_a", out_a, 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;

      // Back-to-back words, one triplet every third cycle
      vcyc.delete();
      push(1, 2, 3, 0);
      push(4, 5, 6, 0);
      for (int w = 1; w <= 6; w++) send(32'(w), 1'b0);
      idle(3);
      #4;
      chk("cad_count", 32'(vcyc.size()), 32'd2);
      if (vcyc.size() >= 2) chk("cad_gap", 32'(vcyc[1] - vcyc[0]), 32'd3);

      // Frame ends at each slot; in_last without in_valid ignored
      push(7, 8, 9, 1);
      push(10, 0, 0, 1);
      push(11, 12, 0, 1);
      send(7, 1'b0);
      @(posedge clk);
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 32'd77;
      send(8, 1'b0);
      send(9, 1'b1);
      send(10, 1'b1);
      send(11, 1'b0);
      send(12, 1'b1);
      idle(3);

      // Stall with a pending word
      out_ready = 1'b0;
      push(1, 2, 3, 0);
      push(4, 5, 6, 0);
      send(1, 1'b0);
      send(2, 1'b0);
      send(3, 1'b0);
      send(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("stall_a", out_a, 32'd1);
         chk("stall_b", out_b, 32'd2);
         chk("stall_c", out_c, 32'd3);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
      end
      out_ready = 1'b1;
      send(5, 1'b0);
      send(6, 1'b0);
      idle(3);

      // Bit-exact extremes
      push(32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 0);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'h8000_0000, 1'b0);
      send(32'h7FFF_FFFF, 1'b0);
      idle(3);

      // Reset mid-triplet
      send(1, 1'b0);
      send(2, 1'b0);
      @(posedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_a", out_a, 32'd0);
      chk("arst_b", out_b, 32'd0);
      chk("arst_c", out_c, 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 32'd99;
      @(negedge clk);
      #1;
      chk("arst_hold_a", out_a, 32'd0);
      @(posedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      push(5, 6, 7, 0);
      send(5, 1'b0);
      send(6, 1'b0);
      send(7, 1'b0);
      idle(3);

      // Consume and complete on the same edge
      vcyc.delete();
      push(40, 41, 42, 0);
      push(43, 0, 0, 1);
      push(44, 0, 0, 1);
      send(40, 1'b0);
      send(41, 1'b0);
      send(42, 1'b0);
      send(43, 1'b1);
      send(44, 1'b1);
      idle(3);
      #4;
      chk("b2b_count", 32'(vcyc.size()), 32'd3);
      if (vcyc.size() >= 3) begin
         chk("b2b_gap0", 32'(vcyc[1] - vcyc[0]), 32'd1);
         chk("b2b_gap1", 32'(vcyc[2] - vcyc[1]), 32'd1);
      end

      chk("sb_drain", 32'(expq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
